// File: rtl/deinterleaver_if.sv
// Bit-serial bus between a block source and the deinterleaver.
// The Sync line exists only when DEINT_SYNC_EN is defined.
interface deinterleaver_if;
    logic Input;
    logic In_Valid;
    logic Output;
    logic Out_Valid;
    logic Block_Start;
`ifdef DEINT_SYNC_EN
    logic Sync;

    modport master (
        output Input, In_Valid, Sync,
        input  Output, Out_Valid, Block_Start
    );
    modport slave (
        input  Input, In_Valid, Sync,
        output Output, Out_Valid, Block_Start
    );
`else
    modport master (
        output Input, In_Valid,
        input  Output, Out_Valid, Block_Start
    );
    modport slave (
        input  Input, In_Valid,
        output Output, Out_Valid, Block_Start
    );
`endif
endinterface

// File: rtl/deinterleaver.sv
// Block bit deinterleaver: column-wise write, row-wise read, ping-pong banks.
// Optional block realign input enabled by defining DEINT_SYNC_EN.
module deinterleaver #(
    parameter int N_CBPS = 48,
    parameter int N_COLS = 16,
    parameter int N_ROWS = N_CBPS / N_COLS
) (
    input  logic           Clock,
    input  logic           Reset,
    deinterleaver_if.slave dif_io
);
    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int KW = (N_CBPS > 1) ? $clog2(N_CBPS) : 1;

    logic [RW-1:0] wr_row_q, wr_row_d;
    logic [CW-1:0] wr_col_q, wr_col_d;
    logic          wr_bank_q, wr_bank_d;
    logic [KW-1:0] rd_cnt_q, rd_cnt_d;
    logic          rd_active_q, rd_active_d;
    logic          out_q, out_d;
    logic          vld_q, vld_d;
    logic          bs_q, bs_d;

    logic [N_CBPS-1:0] bank_q [2];

    logic [RW-1:0] row_eff;
    logic [CW-1:0] col_eff;
    logic [KW-1:0] widx;
    logic          blk_done;

    // A realign restarts the write position before this edge's bit is placed
`ifdef DEINT_SYNC_EN
    assign row_eff = dif_io.Sync ? '0 : wr_row_q;
    assign col_eff = dif_io.Sync ? '0 : wr_col_q;
`else
    assign row_eff = wr_row_q;
    assign col_eff = wr_col_q;
`endif

    assign widx = KW'(row_eff) * KW'(N_COLS) + KW'(col_eff);

    always_comb begin
        wr_row_d  = row_eff;
        wr_col_d  = col_eff;
        wr_bank_d = wr_bank_q;
        blk_done  = 1'b0;
        if (dif_io.In_Valid) begin
            if (row_eff == RW'(N_ROWS - 1)) begin
                wr_row_d = '0;
                if (col_eff == CW'(N_COLS - 1)) begin
                    wr_col_d  = '0;
                    wr_bank_d = ~wr_bank_q;
                    blk_done  = 1'b1;
                end else begin
                    wr_col_d = col_eff + CW'(1);
                end
            end else begin
                wr_row_d = row_eff + RW'(1);
            end
        end
    end

    // Read address rd_cnt maps straight onto row*N_COLS+col of the drained bank
    always_comb begin
        rd_cnt_d    = rd_cnt_q;
        rd_active_d = rd_active_q;
        out_d       = 1'b0;
        vld_d       = 1'b0;
        bs_d        = 1'b0;
        if (rd_active_q) begin
            out_d = bank_q[~wr_bank_q][rd_cnt_q];
            vld_d = 1'b1;
            bs_d  = (rd_cnt_q == '0);
            if (rd_cnt_q == KW'(N_CBPS - 1)) begin
                rd_cnt_d    = '0;
                rd_active_d = 1'b0;
            end else begin
                rd_cnt_d = rd_cnt_q + KW'(1);
            end
        end
        if (blk_done) begin
            rd_cnt_d    = '0;
            rd_active_d = 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            rd_active_q <= 1'b0;
            out_q       <= 1'b0;
            vld_q       <= 1'b0;
            bs_q        <= 1'b0;
        end else begin
            wr_row_q    <= wr_row_d;
            wr_col_q    <= wr_col_d;
            wr_bank_q   <= wr_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_active_q <= rd_active_d;
            out_q       <= out_d;
            vld_q       <= vld_d;
            bs_q        <= bs_d;
        end
    end

    // Bank storage is never reset; nothing reaches Output without Out_Valid
    always_ff @(posedge Clock) begin
        if (dif_io.In_Valid) begin
            bank_q[wr_bank_q][widx] <= dif_io.Input;
        end
    end

    assign dif_io.Output      = out_q;
    assign dif_io.Out_Valid   = vld_q;
    assign dif_io.Block_Start = bs_q;
endmodule
